// File: rtl/game_2048_engine.sv
// 2048 game-logic engine: slides/merges one line per cycle on a working copy,
// spawns random tiles, and commits the finished board to board_state in one cycle.
module game_2048_engine #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  input  logic               new_game,
  input  logic               load_valid,
  input  logic [0:255]       load_board,
  output logic               move_ready,
  output logic [0:255]       board_state,
  output logic [SCORE_W-1:0] score,
  output logic               move_done,
  output logic               moved,
  output logic               game_over
);

  typedef enum logic [1:0] {ST_IDLE, ST_MERGE, ST_SPAWN, ST_CHECK} state_t;

  typedef logic [3:0][15:0] line_t;

  typedef struct packed {
    line_t              res;
    logic [SCORE_W-1:0] gain;
  } merge_t;

  // Position 0 of a line is its leading end, i.e. the edge tiles slide toward.
  function automatic logic [3:0] tile_idx(input logic [1:0] dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    logic [3:0] idx;
    case (dir)
      2'b00:   idx = {pos, line};
      2'b01:   idx = {~pos, line};
      2'b10:   idx = {line, pos};
      default: idx = {line, ~pos};
    endcase
    return idx;
  endfunction

  function automatic merge_t merge_line(input line_t lin);
    logic [4:0][15:0] cmp;
    merge_t           m;
    logic [2:0]       k;
    logic             skip;
    cmp  = '0;
    m    = '0;
    k    = '0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lin[i] != 16'd0) begin
        cmp[k] = lin[i];
        k = k + 3'd1;
      end
    end
    // A merged tile sets skip so its partner cannot merge again this move.
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != 16'd0) begin
        if (cmp[i+1] == cmp[i]) begin
          m.res[k[1:0]] = cmp[i] + 16'd1;
          m.gain = m.gain + (SCORE_W'(1) << (cmp[i] + 16'd1));
          skip = 1'b1;
        end else begin
          m.res[k[1:0]] = cmp[i];
        end
        k = k + 3'd1;
      end
    end
    return m;
  endfunction

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        work_q [16];
  logic [15:0]        work_d [16];
  logic [0:255]       board_q, board_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         line_q, line_d;
  logic               changed_q, changed_d;
  logic [1:0]         spawn_cnt_q, spawn_cnt_d;
  logic [3:0]         ptr_q, ptr_d;
  logic               from_move_q, from_move_d;
  logic               move_done_q, move_done_d;
  logic               moved_q, moved_d;
  logic               game_over_q, game_over_d;

  line_t  line_in;
  merge_t mr;
  logic   line_changed;
  logic   any_move;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      line_in[p] = work_q[tile_idx(dir_q, line_q, 2'(p))];
    end
    mr           = merge_line(line_in);
    line_changed = (mr.res != line_in);
  end

  always_comb begin
    any_move = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (work_q[i] == 16'd0) any_move = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (work_q[r*4+c] == work_q[r*4+c+1]) any_move = 1'b1;
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (work_q[r*4+c] == work_q[r*4+c+4]) any_move = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    work_d      = work_q;
    board_d     = board_q;
    score_d     = score_q;
    dir_d       = dir_q;
    line_d      = line_q;
    changed_d   = changed_q;
    spawn_cnt_d = spawn_cnt_q;
    ptr_d       = ptr_q;
    from_move_d = from_move_q;
    move_done_d = 1'b0;
    moved_d     = 1'b0;
    game_over_d = game_over_q;

    case (state_q)
      ST_IDLE: begin
        if (new_game) begin
          for (int i = 0; i < 16; i++) work_d[i] = '0;
          score_d     = '0;
          spawn_cnt_d = 2'd2;
          ptr_d       = lfsr_q[3:0];
          from_move_d = 1'b0;
          state_d     = ST_SPAWN;
        end else if (load_valid) begin
          for (int i = 0; i < 16; i++) work_d[i] = load_board[16*i +: 16];
          from_move_d = 1'b0;
          state_d     = ST_CHECK;
        end else if (move_valid) begin
          dir_d       = move_dir;
          line_d      = '0;
          changed_d   = 1'b0;
          from_move_d = 1'b1;
          state_d     = ST_MERGE;
        end
      end

      ST_MERGE: begin
        for (int p = 0; p < 4; p++) begin
          work_d[tile_idx(dir_q, line_q, 2'(p))] = mr.res[p];
        end
        score_d   = score_q + mr.gain;
        changed_d = changed_q | line_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (changed_q | line_changed) begin
            spawn_cnt_d = 2'd1;
            ptr_d       = lfsr_q[3:0];
            state_d     = ST_SPAWN;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_SPAWN: begin
        if (work_q[ptr_q] == 16'd0) begin
          work_d[ptr_q] = (lfsr_q[7:4] == 4'd0) ? 16'd2 : 16'd1;
          spawn_cnt_d   = spawn_cnt_q - 2'd1;
          if (spawn_cnt_q == 2'd1) state_d = ST_CHECK;
          else ptr_d = lfsr_q[3:0];
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end

      ST_CHECK: begin
        for (int i = 0; i < 16; i++) board_d[16*i +: 16] = work_q[i];
        game_over_d = ~any_move;
        move_done_d = from_move_q;
        moved_d     = from_move_q & changed_q;
        from_move_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_SPAWN;
      lfsr_q      <= LFSR_SEED;
      for (int i = 0; i < 16; i++) work_q[i] <= '0;
      board_q     <= '0;
      score_q     <= '0;
      dir_q       <= '0;
      line_q      <= '0;
      changed_q   <= 1'b0;
      spawn_cnt_q <= 2'd2;
      ptr_q       <= LFSR_SEED[3:0];
      from_move_q <= 1'b0;
      move_done_q <= 1'b0;
      moved_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      work_q      <= work_d;
      board_q     <= board_d;
      score_q     <= score_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      changed_q   <= changed_d;
      spawn_cnt_q <= spawn_cnt_d;
      ptr_q       <= ptr_d;
      from_move_q <= from_move_d;
      move_done_q <= move_done_d;
      moved_q     <= moved_d;
      game_over_q <= game_over_d;
    end
  end

  assign move_ready  = (state_q == ST_IDLE);
  assign board_state = board_q;
  assign score       = score_q;
  assign move_done   = move_done_q;
  assign moved       = moved_q;
  assign game_over   = game_over_q;

endmodule

// File: doc/game_2048_engine.md
Name: game_2048_engine

Overview:
- Game-logic writer for the 16-tile board consumed by the VGA board renderer.
- Accepts one move command at a time, then slides and merges tiles and spawns a random tile.
- Detects game over and commits the new board atomically to board_state, so the renderer never sees a partial move.
- Sits beside the VGA controller in the top level, on the display clock domain.

Parameters:
LFSR_SEED, 16'hACE1, nonzero reset value of the spawn LFSR
SCORE_W, 32, score register width

Ports:
clk  in  1  block clock
clr  in  1  asynchronous active-high reset
move_valid  in  1  move request; accepted only when move_ready=1
move_dir  in  2  00 up, 01 down, 10 left, 11 right
new_game  in  1  restart request, sampled only in IDLE
load_valid  in  1  debug/verification board load, sampled only in IDLE
load_board  in  256  board image for load, same layout as board_state
move_ready  out  1  high only in IDLE
board_state  out  [0:255]  16 tiles x 16 bits, row-major; tile i at bits [16i:16i+15]; tile 0 top-left; value = log2(tile), 0 = empty
score  out  SCORE_W  running score
move_done  out  1  one-cycle pulse when a move completes
moved  out  1  valid with move_done: 1 if any tile changed
game_over  out  1  no empty tile and no equal orthogonal neighbours

Behaviour:
- Reset (clr high, async):
  - board_state, working copy and score = 0; move_done, moved, game_over = 0.
  - LFSR = LFSR_SEED; state = SPAWN with spawn_cnt = 2.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle.
- States:
  - IDLE: priority new_game > load_valid > move_valid.
    - new_game: clear working copy and score, go to SPAWN with spawn_cnt = 2.
    - load_valid: working copy = load_board, score unchanged, go to CHECK; no move_done pulse.
    - move_valid: latch move_dir, line = 0, change flag = 0, go to MERGE.
  - MERGE: 4 cycles; one line per cycle (line 0..3), written back to the working copy.
    - Line read order: left = row i, columns 0→3; right = row i, columns 3→0; up = column i, rows 0→3; down = column i, rows 3→0.
    - Per line: compact nonzero tiles toward the leading end. Merge equal adjacent pairs scanning from the leading end; each tile merges at most once per move.
    - Each merge of exponent e produces e+1 and adds 1<<(e+1) to score; score wraps modulo 2^SCORE_W.
    - Change flag sets if any tile position or value differs.
    - After line 3: change flag = 1 → SPAWN (spawn_cnt = 1); otherwise → CHECK.
  - SPAWN:
    - On entry, scan pointer = LFSR[3:0].
    - Each cycle, test one tile. If empty, write exponent 2 when LFSR[7:4] = 0, else exponent 1. Then decrement spawn_cnt; when it reaches 0 go to CHECK, else reload the pointer from the LFSR and continue.
    - If not empty, pointer increments modulo 16.
    - At most 16 cycles per tile. An empty tile always exists after a changing move or a clear.
  - CHECK: one cycle.
    - Copy working copy to board_state.
    - game_over = no zero tile and no horizontally or vertically adjacent equal tiles.
    - Next state IDLE. On entry from a move, register move_done = 1 and moved = change flag for the first IDLE cycle.
- Latency, move accepted at cycle T:
  - Unchanged board: move_done at T+6.
  - Changed board: move_done at T+6+k, where k = 1..16 spawn cycles.
- move_valid, new_game and load_valid outside IDLE are ignored, not queued.
- game_over does not block moves. A move on a game-over board returns moved = 0.
- clr mid-MERGE or mid-SPAWN aborts immediately; no partial board is ever committed.

Test Plan:
- Reset, then run until move_ready:
  - Within 34 cycles, board_state has exactly two nonzero tiles, each 1 or 2.
  - score = 0, game_over = 0.
- Load row0 = [1,1,1,1], rest 0; move left:
  - row0 = [2,2,0,0], score += 8, moved = 1.
  - Exactly one new tile (1 or 2) in a previously empty cell.
- Load row0 = [1,0,1,2], rest 0; move left:
  - row0 = [2,2,0,0], score += 4.
- Load column0 = [0,1,1,1], rest 0; move down:
  - column0 (top→bottom) = [0,0,1,2], score += 4.
- Load only row0 = [2,1,0,0]; move left:
  - board unchanged, moved = 0, move_done exactly 6 cycles after acceptance.
- Load full checkerboard of 1/2:
  - game_over = 1 after CHECK; all four directions give moved = 0.
  - Assert clr during a SPAWN: board_state = 0 immediately, and two tiles reappear after reset.
